// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: 4x8 register file, operand
// latching, ALU_LAT settle wait, result/flag capture and one-cycle writeback pulse.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [4:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs1,
    input  logic [1:0] instr_rs2,
    input  logic       instr_use_imm,
    input  logic [7:0] instr_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [4:0] alu_choice,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_borrow,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [7:0] wb_data,
    output logic       wb_err,
    output logic [4:0] flags,
    output logic       err,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    localparam int         CW     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [4:0] OP_MAX = 5'b10011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_regs [4];
    logic [1:0]      r_rd;
    logic            r_illegal;
    logic            r_ready;
    logic [7:0]      r_alu_a;
    logic [7:0]      r_alu_b;
    logic [4:0]      r_alu_choice;
    logic            r_wb_valid;
    logic [1:0]      r_wb_rd;
    logic [7:0]      r_wb_data;
    logic            r_wb_err;
    logic [4:0]      r_flags;
    logic            r_err;

    logic            w_accept;
    logic [7:0]      w_opb;

    assign w_accept = instr_valid && r_ready;
    assign w_opb    = instr_use_imm ? instr_imm : r_regs[instr_rs2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            r_rd         <= '0;
            r_illegal    <= 1'b0;
            r_ready      <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_choice <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_wb_err     <= 1'b0;
            r_flags      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a      <= r_regs[instr_rs1];
                        r_alu_b      <= w_opb;
                        r_alu_choice <= instr_op;
                        r_rd         <= instr_rd;
                        r_illegal    <= (instr_op > OP_MAX);
                        r_cnt        <= CW'(ALU_LAT - 1);
                        r_ready      <= 1'b0;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        // Illegal ops still produce a writeback pulse, but touch no architectural state besides err.
                        if (!r_illegal) begin
                            r_regs[r_rd] <= alu_result;
                            r_flags      <= {alu_overflow, alu_negative, alu_zero, alu_borrow, alu_carry};
                            r_wb_data    <= alu_result;
                        end else begin
                            r_err        <= 1'b1;
                            r_wb_data    <= '0;
                        end
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_err   <= r_illegal;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_wb_valid <= 1'b0;
                    r_wb_rd    <= '0;
                    r_wb_data  <= '0;
                    r_wb_err   <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_choice  = r_alu_choice;
    assign wb_valid    = r_wb_valid;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign wb_err      = r_wb_err;
    assign flags       = r_flags;
    assign err         = r_err;
    assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a small behavioural ALU (add, sub, pass-B)
// on the alutop side; directed instructions push hand-computed writebacks.
module tb_alu_issue_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [4:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic       instr_use_imm;
    logic [7:0] instr_imm;
    logic [7:0] alu_a, alu_b;
    logic [4:0] alu_choice;
    logic [7:0] alu_result;
    logic       alu_carry, alu_borrow, alu_zero, alu_negative, alu_overflow;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       wb_err;
    logic [4:0] flags;
    logic       err;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_use_imm(instr_use_imm),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_choice   (alu_choice),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_borrow   (alu_borrow),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_err       (wb_err),
        .flags        (flags),
        .err          (err),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    // Unknown opcodes return a loud pattern so a wrongful write would be visible.
    always_comb begin
        logic [8:0] sum;
        sum          = '0;
        alu_result   = 8'hA5;
        alu_carry    = 1'b1;
        alu_borrow   = 1'b1;
        alu_zero     = 1'b1;
        alu_negative = 1'b1;
        alu_overflow = 1'b1;
        case (alu_choice)
            5'b00000: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum[7:0];
                alu_carry    = sum[8];
                alu_borrow   = 1'b0;
                alu_overflow = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
                alu_zero     = (sum[7:0] == 8'h00);
                alu_negative = sum[7];
            end
            5'b00001: begin
                alu_result   = alu_a - alu_b;
                alu_carry    = 1'b0;
                alu_borrow   = alu_a < alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
                alu_zero     = (alu_result == 8'h00);
                alu_negative = alu_result[7];
            end
            5'b10011: begin
                alu_result   = alu_b;
                alu_carry    = 1'b0;
                alu_borrow   = 1'b0;
                alu_overflow = 1'b0;
                alu_zero     = (alu_b == 8'h00);
                alu_negative = alu_b[7];
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
        logic       werr;
        logic [4:0] flg;
        logic       sticky;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] op;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   wb_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wb_valid) begin
            exp_t e;
            wb_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d data=%0h expected no writeback", wb_rd, wb_data);
            end else begin
                e = q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", 32'(wb_data), 32'(e.data));
                chk("wb_err", 32'(wb_err), 32'(e.werr));
                chk("flags", 32'(flags), 32'(e.flg));
                chk("err_sticky", 32'(err), 32'(e.sticky));
                chk("alu_a_hold", 32'(alu_a), 32'(e.a));
                chk("alu_b_hold", 32'(alu_b), 32'(e.b));
                chk("alu_choice_hold", 32'(alu_choice), 32'(e.op));
                chk("latency", 32'(cyc - e.acc), 32'(LAT));
            end
        end
    end

    // Called and returns on a falling edge; drives one instruction until accepted.
    task automatic issue(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic use_imm, input logic [7:0] imm,
                         input bit push, input bit hold,
                         input logic [7:0] e_data, input logic e_werr, input logic [4:0] e_flg,
                         input logic e_sticky, input logic [7:0] e_a, input logic [7:0] e_b,
                         output int waited);
        exp_t e;
        instr_valid   = 1'b1;
        instr_op      = op;
        instr_rd      = rd;
        instr_rs1     = rs1;
        instr_rs2     = rs2;
        instr_use_imm = use_imm;
        instr_imm     = imm;
        waited        = 0;
        while (!instr_ready) begin
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got instr_ready=0 for %0d cycles expected 1", waited);
                instr_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (push) begin
            e = '{rd: rd, data: e_data, werr: e_werr, flg: e_flg, sticky: e_sticky,
                  a: e_a, b: e_b, op: op, acc: cyc};
            q.push_back(e);
        end
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'h0);
        chk({tag, "_alu_b"}, 32'(alu_b), 32'h0);
        chk({tag, "_alu_choice"}, 32'(alu_choice), 32'h0);
        chk({tag, "_flags"}, 32'(flags), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_wb"}, 32'({wb_valid, wb_rd, wb_data, wb_err}), 32'h0);
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
        logic [7:0] ev [4];
        ev = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(ev[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d writebacks pending", q.size());
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op = '0;
        instr_rd = '0;
        instr_rs1 = '0;
        instr_rs2 = '0;
        instr_use_imm = 1'b0;
        instr_imm = '0;
        dbg_sel = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        chk_regs("por", 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(instr_ready), 32'h1);

        // Load r1=7F, r2=01, then r3 = r1 + r2 (signed overflow into negative).
        issue(5'b10011, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 1, 0, 8'h7F, 0, 5'b00000, 0, 8'h00, 8'h7F, w);
        issue(5'b10011, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01, 1, 0, 8'h01, 0, 5'b00000, 0, 8'h00, 8'h01, w);
        issue(5'b00000, 2'd3, 2'd1, 2'd2, 1'b0, 8'hEE, 1, 0, 8'h80, 0, 5'b11000, 0, 8'h7F, 8'h01, w);
        // Illegal op: writeback flagged, no state change besides err.
        issue(5'b10111, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 1, 0, 8'h00, 1, 5'b11000, 1, 8'h7F, 8'h01, w);
        repeat (LAT + 2) @(negedge clk);
        chk_regs("after_illegal", 8'h00, 8'h7F, 8'h01, 8'h80);
        chk("err_set", 32'(err), 32'h1);

        // r1=2A, then r1 = r1 - r1 reads pre-write operands.
        issue(5'b10011, 2'd1, 2'd0, 2'd0, 1'b1, 8'h2A, 1, 0, 8'h2A, 0, 5'b00000, 1, 8'h00, 8'h2A, w);
        issue(5'b00001, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 1, 0, 8'h00, 0, 5'b00100, 1, 8'h2A, 8'h2A, w);

        // Back-to-back with instr_valid held high throughout.
        issue(5'b00000, 2'd0, 2'd2, 2'd2, 1'b0, 8'h00, 1, 1, 8'h02, 0, 5'b00000, 1, 8'h01, 8'h01, w);
        issue(5'b00000, 2'd2, 2'd0, 2'd3, 1'b1, 8'h03, 1, 0, 8'h05, 0, 5'b00000, 1, 8'h02, 8'h03, w);
        chk("backpressure_wait", 32'(w), 32'(LAT + 1));
        repeat (LAT + 2) @(negedge clk);
        chk_regs("after_bp", 8'h02, 8'h00, 8'h05, 8'h80);
        chk("wb_count_pre_abort", 32'(wb_cnt), 32'd8);

        // Abort an ADD to r3 mid-EXEC with a reset pulse between clock edges.
        issue(5'b00000, 2'd3, 2'd0, 2'd2, 1'b0, 8'h00, 0, 0, 8'h00, 0, 5'b00000, 0, 8'h00, 8'h00, w);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("abort");
        chk("abort_ready", 32'(instr_ready), 32'h1);
        #1 rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        chk_regs("after_abort", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("abort_idle_ready", 32'(instr_ready), 32'h1);
        chk("wb_count_final", 32'(wb_cnt), 32'd8);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 1, number of cycles (>=1) the alutop outputs are allowed to settle before capture.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  instruction accepted when instr_valid && instr_ready at a rising edge.
REQ-006 instr_op  input  5  ALU choice code; 5'b00000..5'b10011 legal.
REQ-007 instr_rd, instr_rs1, instr_rs2  input  2 each  destination and source register indices.
REQ-008 instr_use_imm  input  1  when 1, operand B is instr_imm instead of reg[rs2].
REQ-009 instr_imm  input  8  immediate operand.
REQ-010 alu_a, alu_b  output  8 each  operands to alutop, registered.
REQ-011 alu_choice  output  5  opcode to alutop, registered.
REQ-012 alu_result  input  8  alutop result.
REQ-013 alu_carry, alu_borrow, alu_zero, alu_negative, alu_overflow  input  1 each  alutop flags.
REQ-014 wb_valid  output  1  one-cycle writeback pulse.
REQ-015 wb_rd  output  2; wb_data  output  8; wb_err  output  1  writeback index, value, illegal-op marker.
REQ-016 flags  output  5  status register {overflow, negative, zero, borrow, carry}.
REQ-017 err  output  1  sticky illegal-op indicator.
REQ-018 dbg_sel  input  2; dbg_data  output  8  combinational read of reg[dbg_sel].

Function
REQ-019 Register file: four 8-bit registers r0..r3, all general purpose (r0 not hardwired).
REQ-020 FSM states IDLE, EXEC, DONE; IDLE->EXEC on accept; EXEC->DONE after ALU_LAT cycles; DONE->IDLE unconditionally.
REQ-021 instr_ready = 1 only in IDLE; no instruction queuing; held instr_valid in other states has no effect.
REQ-022 On accept edge: alu_a <= reg[rs1]; alu_b <= instr_use_imm ? instr_imm : reg[rs2]; alu_choice <= instr_op; rd and legality latched.
REQ-023 alu_a, alu_b, alu_choice hold stable throughout EXEC and DONE.
REQ-024 EXEC down-counter loaded with ALU_LAT-1 on accept; capture on the edge where it reads 0.
REQ-025 Legal op capture: reg[rd] <= alu_result; flags <= {alu_overflow, alu_negative, alu_zero, alu_borrow, alu_carry}.
REQ-026 Illegal op (>5'b10011): no register or flags write; err <= 1; capture edge otherwise identical.
REQ-027 DONE: wb_valid=1, wb_rd=latched rd, wb_data=captured result (8'h00 if illegal), wb_err=illegal; all four 0 in other states.
REQ-028 Latency: accept edge T -> wb_valid high in the cycle after T+ALU_LAT edges; next accept no earlier than the cycle after DONE; throughput one instruction per ALU_LAT+2 cycles.
REQ-029 rd may equal rs1/rs2; operands come from pre-write values (latched at accept).
REQ-030 err cleared only by rst.

Reset
REQ-031 rst asserted: state=IDLE, r0..r3=8'h00, alu_a=alu_b=8'h00, alu_choice=5'b00000, flags=5'b00000, err=0, wb_valid=0, wb_rd=0, wb_data=0, wb_err=0, counter=0, independent of clk.
REQ-032 rst during EXEC or DONE aborts the instruction: no register write, no wb_valid pulse.
REQ-033 instr_ready=1 in the first cycle after rst deasserts.

Verification
REQ-034 Reset: pulse rst between edges -> all outputs at REQ-031 values immediately; instr_ready=1 after release; dbg_data=0 for all dbg_sel.
REQ-035 Load r1: op 10011, rd=1, imm 8'h7F, use_imm=1; load r2 with 8'h01; ADD op 00000 rd=3 rs1=1 rs2=2 -> r3=8'h80, flags=5'b11000, wb_valid exactly ALU_LAT+1 cycles after accept.
REQ-036 Illegal op 5'b10111, rd=0 -> wb_valid with wb_err=1, wb_data=8'h00, err=1 sticky, r0..r3 and flags unchanged.
REQ-037 Backpressure: instr_valid held high across two instructions -> instr_ready low in EXEC/DONE, second accepted only in next IDLE, exactly two wb_valid pulses, none lost or duplicated.
REQ-038 rst asserted mid-EXEC of ADD to r3 -> no wb_valid, r3=8'h00, IDLE after release.
REQ-039 SUB op 00001 rd=rs1=rs2=1 with r1=8'h2A -> r1=8'h00, zero flag (flags[2])=1.
